// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: ID-stage forwarding selects,
// load-use bubbles, branch flushes and a MEM-wait freeze FSM with timeout.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_reg1_read,
    input  logic             id_reg2_read,
    input  logic             id_branch_or_jump,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_wreg,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_wreg,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_wreg,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       red1_select_signal,
    output logic [1:0]       red2_select_signal,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_all,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wcnt, wcnt_nxt;
    logic            lu, mem_miss;

    // A load in EX cannot forward yet; that case is handled as a load-use stall.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] op,
        input logic       exw, exm,
        input logic [4:0] exd,
        input logic       mw,
        input logic [4:0] md,
        input logic       ww,
        input logic [4:0] wd
    );
        if (op == 5'd0)                      return 2'b00;
        else if (exw && !exm && exd == op)   return 2'b01;
        else if (mw && md == op)             return 2'b10;
        else if (ww && wd == op)             return 2'b11;
        else                                 return 2'b00;
    endfunction

    assign lu = ex_regwrite && ex_memtoreg && (ex_wreg != 5'd0) &&
                ((id_reg1_read && ex_wreg == id_rs) || (id_reg2_read && ex_wreg == id_rt));
    assign mem_miss = dmem_req && !dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: if (mem_miss) begin
                state_nxt = MEM_WAIT;
                wcnt_nxt  = WC_W'(1);
            end
            MEM_WAIT: if (dmem_ready) begin
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end else begin
                wcnt_nxt = wcnt + WC_W'(1);
                if (wcnt_nxt == WC_W'(MEM_TIMEOUT)) state_nxt = ERR;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    // All combinational outputs are forced low while reset is asserted.
    always_comb begin
        red1_select_signal = 2'b00;
        red2_select_signal = 2'b00;
        stall_pc           = 1'b0;
        stall_if_id        = 1'b0;
        flush_if_id        = 1'b0;
        flush_id_ex        = 1'b0;
        freeze_all         = 1'b0;
        if (rst_n) begin
            red1_select_signal = fwd_sel(id_rs, ex_regwrite, ex_memtoreg, ex_wreg,
                                         mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
            red2_select_signal = fwd_sel(id_rt, ex_regwrite, ex_memtoreg, ex_wreg,
                                         mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        freeze_all  = 1'b1;
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                    end else if (lu) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (id_branch_or_jump) begin
                        flush_if_id = 1'b1;
                    end
                end
                default: begin
                    freeze_all  = 1'b1;
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (state_nxt == ERR) bus_err <= 1'b1;
            if (stall_pc && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed scoreboard bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
    localparam int TO    = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       r1, r2, br;
        logic       exw, exm;
        logic [4:0] exd;
        logic       mw;
        logic [4:0] md;
        logic       ww;
        logic [4:0] wd;
        logic       req, rdy;
    } vec_t;

    typedef struct {
        int sel1, sel2, spc, sifid, fifid, fidex, frz, berr, scnt;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
    logic id_reg1_read, id_reg2_read, id_branch_or_jump;
    logic ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite, dmem_req, dmem_ready;
    logic [1:0] red1_select_signal, red2_select_signal;
    logic stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze_all, bus_err;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
        .id_branch_or_jump(id_branch_or_jump), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite),
        .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .red1_select_signal(red1_select_signal), .red2_select_signal(red2_select_signal),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .freeze_all(freeze_all), .bus_err(bus_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0, miscompares = 0;

    // Reference model state: pipeline mode, consecutive unfinished-access cycles,
    // error flag and stall counter.
    bit waiting = 0, failed = 0;
    int miss_run = 0, m_scnt = 0;

    function automatic int pick_src(input vec_t v, input logic [4:0] op);
        if (op == 0) return 0;
        if (v.exw && !v.exm && v.exd == op) return 1;
        if (v.mw && v.md == op) return 2;
        if (v.ww && v.wd == op) return 3;
        return 0;
    endfunction

    function automatic vec_t idle();
        vec_t v;
        v = '{rst: 1'b1, rs: 5'd0, rt: 5'd0, r1: 1'b0, r2: 1'b0, br: 1'b0,
              exw: 1'b0, exm: 1'b0, exd: 5'd0, mw: 1'b0, md: 5'd0,
              ww: 1'b0, wd: 5'd0, req: 1'b0, rdy: 1'b1};
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        bit   lu, frozen;
        @(negedge clk);
        rst_n = v.rst; id_rs = v.rs; id_rt = v.rt; id_reg1_read = v.r1; id_reg2_read = v.r2;
        id_branch_or_jump = v.br; ex_regwrite = v.exw; ex_memtoreg = v.exm; ex_wreg = v.exd;
        mem_regwrite = v.mw; mem_wreg = v.md; wb_regwrite = v.ww; wb_wreg = v.wd;
        dmem_req = v.req; dmem_ready = v.rdy;
        e = '{default: 0};
        if (!v.rst) begin
            waiting = 0; failed = 0; miss_run = 0; m_scnt = 0;
            q.push_back(e);
            return;
        end
        e.sel1 = pick_src(v, v.rs);
        e.sel2 = pick_src(v, v.rt);
        lu = v.exw && v.exm && v.exd != 0 &&
             ((v.r1 && v.exd == v.rs) || (v.r2 && v.exd == v.rt));
        frozen = failed || waiting || (v.req && !v.rdy);
        if (frozen) begin
            e.frz = 1; e.spc = 1; e.sifid = 1;
        end else if (lu) begin
            e.spc = 1; e.sifid = 1; e.fidex = 1;
        end else if (v.br) begin
            e.fifid = 1;
        end
        e.berr = failed;
        e.scnt = m_scnt;
        q.push_back(e);
        // Clock-edge effects on the model.
        if (e.spc && m_scnt < CMAX) m_scnt++;
        if (!failed) begin
            if (waiting && v.rdy) begin
                waiting = 0; miss_run = 0;
            end else if (waiting || (v.req && !v.rdy)) begin
                waiting = 1; miss_run++;
                if (miss_run >= TO) failed = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                chk("sel1", red1_select_signal, e.sel1);
                chk("sel2", red2_select_signal, e.sel2);
                chk("stall_pc", stall_pc, e.spc);
                chk("stall_if_id", stall_if_id, e.sifid);
                chk("flush_if_id", flush_if_id, e.fifid);
                chk("flush_id_ex", flush_id_ex, e.fidex);
                chk("freeze_all", freeze_all, e.frz);
                chk("bus_err", bus_err, e.berr);
                chk("stall_cycles", stall_cycles, e.scnt);
            end
        end
    end

    initial begin
        vec_t v;
        v = idle(); v.rst = 1'b0;
        v.rs = 5; v.exw = 1; v.exd = 5; // reset must mask even a live forward match
        step(v);
        step(v);
        // Forwarding priority on rs.
        v = idle(); v.rs = 5; v.exw = 1; v.exd = 5; v.mw = 1; v.md = 5; v.ww = 1; v.wd = 5;
        step(v);
        v.exw = 0; step(v);
        v.mw = 0;  step(v);
        v = idle(); v.ww = 1; v.mw = 1; v.exw = 1; step(v);
        // Load-use, then the load forwards from MEM.
        v = idle(); v.exw = 1; v.exm = 1; v.exd = 8; v.rt = 8; v.r2 = 1; step(v);
        v = idle(); v.mw = 1; v.md = 8; v.rt = 8; v.r2 = 1; v.req = 1; v.rdy = 1; step(v);
        v = idle(); v.exw = 1; v.exm = 1; v.exd = 8; v.rt = 8; v.r2 = 0; step(v);
        v = idle(); v.exw = 1; v.exm = 1; v.exd = 0; v.rt = 0; v.r2 = 1; step(v);
        // Branch alone, then branch with load-use.
        v = idle(); v.br = 1; step(v);
        v = idle(); step(v);
        v = idle(); v.br = 1; v.exw = 1; v.exm = 1; v.exd = 3; v.rs = 3; v.r1 = 1; step(v);
        // Memory wait of 3 cycles, branch arriving mid-wait.
        v = idle(); v.req = 1; v.rdy = 0; step(v);
        step(v);
        v.br = 1; step(v);
        v.br = 0; v.rdy = 1; step(v);
        v = idle(); step(v);
        // Timeout into ERR, linger long enough to saturate the counter, then reset.
        v = idle(); v.req = 1; v.rdy = 0;
        for (int i = 0; i < 75; i++) step(v);
        v.rst = 0; step(v);
        v = idle(); step(v);
        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            v.rst = ($urandom_range(0, 59) != 0);
            v.rs  = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
            v.r1  = 1'($urandom); v.r2 = 1'($urandom); v.br = ($urandom_range(0, 3) == 0);
            v.exw = 1'($urandom); v.exm = 1'($urandom); v.exd = 5'($urandom_range(0, 3));
            v.mw  = 1'($urandom); v.md = 5'($urandom_range(0, 3));
            v.ww  = 1'($urandom); v.wd = 5'($urandom_range(0, 3));
            v.req = ($urandom_range(0, 3) == 0); v.rdy = ($urandom_range(0, 3) != 0);
            step(v);
        end
        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
